bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumer end of the BCD counter's digit bus. Accepts a packed multi-digit BCD word through a valid/ready handshake and drives a time-multiplexed 7-segment display with one-hot digit select.
- A 1-deep staging buffer swaps into the display register only at frame boundaries, so a frame never shows a mix of old and new digits.
- Blanks leading zeros and flags invalid BCD codes.

Parameters:
- DIGITS, 4, number of BCD digits and digit-select lines (>=2)
- PRESCALE, 1000, clock cycles per digit slot (>=2)
- BLANK_LEADING, 1, 1 = suppress leading zeros; 0 = show all digits

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  scan enable; when low, prescaler, digit index and outputs hold
- bcd_in  input  4*DIGITS  packed BCD; nibble 0 (bits 3:0) is the least significant digit
- bcd_valid  input  1  bcd_in is valid
- bcd_ready  output  1  staging buffer empty; transfer occurs when valid && ready
- seg  output  7  active-high segments, bit0=a ... bit6=g
- dig_sel  output  DIGITS  one-hot active-high digit enable; bit i = digit i
- err  output  1  sticky flag: an invalid nibble (>9) was accepted

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, index=0, display register=all zeros, staging empty, err=0
  - seg=0x00, dig_sel=0
  - bcd_ready=1 (combinational: !staging_full)
- Handshake:
  - Accept on a rising edge where bcd_valid && bcd_ready; staging <= bcd_in, staging_full <= 1.
  - Accept is independent of ena.
  - bcd_valid may stay high across cycles; each accept consumes one word.
- Prescaler (only while ena=1):
  - Counts 0..PRESCALE-1.
  - On PRESCALE-1 it wraps to 0 and index advances; index wraps DIGITS-1 -> 0.
- Frame boundary is the edge where index wraps DIGITS-1 -> 0. On that edge, if staging_full: display <= staging and staging_full <= 0.
  - The new frame's digit 0 already shows the new data.
  - bcd_ready rises the following cycle.
  - A bcd_valid in the boundary cycle is not accepted (ready was low).
- Outputs are registered, updated every enabled cycle:
  - dig_sel = one-hot(index), one cycle after index changes.
  - seg = pattern of display digit[index], one cycle after index changes.
- Segment patterns:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - invalid (10-15) = 0x40 (dash)
  - blank = 0x00
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i is blanked iff digit i and every higher digit are 0 and i != 0.
  - Digit 0 is always shown.
  - An invalid nibble is never blanked and stops blanking for all lower digits.
- err:
  - Set on any accept where some nibble >9.
  - Cleared only by reset.
  - The invalid word is still displayed, with dashes in the invalid positions.
- ena=0:
  - All scan state and seg/dig_sel hold.
  - No display swap (no boundary occurs).
  - Staging still accepts if empty.
- Reset mid-frame: immediate return to the reset state; staged data is discarded.

Test Plan (bench uses DIGITS=4, PRESCALE=4, BLANK_LEADING=1):
1. Reset release, ena=1, no input -> after the first edge dig_sel=0001, seg=0x3F. Digits 1-3 get seg=0x00; dig_sel walks 0001->0010->0100->1000 every 4 cycles and wraps.
2. Send 0x0407 (valid one cycle) mid-frame -> bcd_ready low from the next cycle until the frame boundary. Old data until the boundary, then digit0=0x07, digit1=0x00 (blank since digits 2 and 3 are 0? no: digit2=4 nonzero, so digit1 "0" shown = 0x3F), digit2=0x66, digit3=0x00. bcd_ready returns high.
3. Back-to-back 0x1234 then 0x5678 with valid held -> second word is accepted only after the boundary swap. The 1234 frame is fully displayed (0x66, 0x4F, 0x5B, 0x06 for digits 0-3) before 5678 appears; no torn frame.
4. Send 0x00A0 -> err=1 and stays 1. Digit1=0x40, digit0=0x3F, digits 2-3 blank. A subsequent valid word leaves err=1 until reset.
5. ena low for 20 cycles mid-frame -> seg, dig_sel and prescaler frozen. A word sent meanwhile is accepted (bcd_ready falls) but not displayed until ena returns and the boundary passes.
6. rst_n pulsed low while staging full and index=2 -> seg=0x00, dig_sel=0 and bcd_ready=1 asynchronously. After release the display shows all-zero (0x3F on digit 0 only).

Source files
------------

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - multiplexed 7-segment scanner for a packed BCD digit bus
//
// Takes a packed BCD word over a valid/ready handshake into a 1-deep
// staging buffer. The staged word moves into the display register only at a
// frame boundary, so one scan frame never mixes digits from two words.
// Digits are scanned one slot per PRESCALE enabled cycles. Leading zeros can
// be blanked, and invalid codes are shown as a dash.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        scan enable; when low, the scan state and outputs hold
//   bcd_in     packed BCD, nibble 0 = least significant digit
//   bcd_valid  bcd_in is valid
//   bcd_ready  staging buffer empty; a word transfers when valid && ready
//   seg        active-high segments, bit0 = a ... bit6 = g (registered)
//   dig_sel    one-hot active-high digit enable (registered)
//   err        sticky: an invalid nibble (>9) was accepted

module bcd_display_scanner #(
   parameter int DIGITS        = 4,
   parameter int PRESCALE      = 1000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  bcd_valid,
   output logic                  bcd_ready,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  err
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [PW-1:0]          presc_q, presc_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0]    disp_q, disp_d;
   logic [4*DIGITS-1:0]    stage_q, stage_d;
   logic                   stage_full_q, stage_full_d;
   logic                   err_q, err_d;
   logic [6:0]             seg_q, seg_d;
   logic [DIGITS-1:0]      dig_sel_q, dig_sel_d;

   logic [3:0]             disp_nib [DIGITS];
   logic [DIGITS-1:0]      blank;
   logic                   lead;
   logic                   in_bad;
   logic [6:0]             seg_cur;
   logic                   accept;
   logic                   presc_wrap;
   logic                   frame_end;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h40;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         disp_nib[i] = disp_q[4*i +: 4];
      end
   end

   // Walk down from the most significant digit; the first nonzero nibble
   // (invalid codes included) ends the leading-zero run. Digit 0 is never
   // blanked so a zero value still shows "0".
   always_comb begin
      lead  = (BLANK_LEADING != 0);
      blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (disp_nib[i] == 4'd0)) begin
            blank[i] = 1'b1;
         end else begin
            lead = 1'b0;
         end
      end
   end

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            in_bad = 1'b1;
         end
      end
   end

   assign seg_cur    = blank[idx_q] ? 7'h00 : seg_decode(disp_nib[idx_q]);
   assign accept     = bcd_valid && !stage_full_q;
   assign presc_wrap = (presc_q == PRESC_LAST);
   assign frame_end  = ena && presc_wrap && (idx_q == IDX_LAST);

   always_comb begin
      presc_d      = presc_q;
      idx_d        = idx_q;
      disp_d       = disp_q;
      stage_d      = stage_q;
      stage_full_d = stage_full_q;
      err_d        = err_q;
      seg_d        = seg_q;
      dig_sel_d    = dig_sel_q;

      // Accept needs an empty buffer and a swap needs a full one, so the
      // two never collide on the same edge.
      if (accept) begin
         stage_d      = bcd_in;
         stage_full_d = 1'b1;
         if (in_bad) begin
            err_d = 1'b1;
         end
      end

      if (ena) begin
         if (presc_wrap) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
         // Outputs follow the current index, so they lag it by one cycle.
         dig_sel_d        = '0;
         dig_sel_d[idx_q] = 1'b1;
         seg_d            = seg_cur;
      end

      if (frame_end && stage_full_q) begin
         disp_d       = stage_q;
         stage_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         disp_q       <= '0;
         stage_q      <= '0;
         stage_full_q <= 1'b0;
         err_q        <= 1'b0;
         seg_q        <= 7'h00;
         dig_sel_q    <= '0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         stage_q      <= stage_d;
         stage_full_q <= stage_full_d;
         err_q        <= err_d;
         seg_q        <= seg_d;
         dig_sel_q    <= dig_sel_d;
      end
   end

   assign bcd_ready = !stage_full_q;
   assign seg       = seg_q;
   assign dig_sel   = dig_sel_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - scoreboard bench for bcd_display_scanner

module tb_bcd_display_scanner;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                ena;
   logic [4*DIGITS-1:0] bcd_in;
   logic                bcd_valid;
   logic                bcd_ready;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   dig_sel;
   logic                err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0]        exp_q [$];
   logic [DIGITS-1:0] dsel_prev;

   bcd_display_scanner #(
      .DIGITS(DIGITS),
      .PRESCALE(PRESCALE),
      .BLANK_LEADING(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ena(ena),
      .bcd_in(bcd_in),
      .bcd_valid(bcd_valid),
      .bcd_ready(bcd_ready),
      .seg(seg),
      .dig_sel(dig_sel),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) dsel_prev <= dig_sel;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'd0: ref_seg = 7'h3F;  4'd1: ref_seg = 7'h06;
         4'd2: ref_seg = 7'h5B;  4'd3: ref_seg = 7'h4F;
         4'd4: ref_seg = 7'h66;  4'd5: ref_seg = 7'h6D;
         4'd6: ref_seg = 7'h7D;  4'd7: ref_seg = 7'h07;
         4'd8: ref_seg = 7'h7F;  4'd9: ref_seg = 7'h6F;
         default: ref_seg = 7'h40;
      endcase
   endfunction

   // Expected segment values of one frame, pushed digit 0 first.
   task automatic push_frame(input logic [15:0] w);
      logic [6:0] e [4];
      logic       lead;
      logic [3:0] nb;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nb = w[4*i +: 4];
         if (i != 0 && lead && nb == 4'd0) begin
            e[i] = 7'h00;
         end else begin
            lead = 1'b0;
            e[i] = ref_seg(nb);
         end
      end
      for (int i = 0; i < DIGITS; i++) exp_q.push_back(e[i]);
   endtask

   // Waits for the negedge where dig_sel has just switched to sel.
   task automatic wait_sel_start(input logic [DIGITS-1:0] sel, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 4 * DIGITS * PRESCALE; k++) begin
         @(negedge clk);
         if (dig_sel == sel && dsel_prev != sel) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Scoreboard drain: samples every slot of the next frame.
   task automatic drain_frame(input string name);
      bit                ok;
      logic [6:0]        e;
      logic [DIGITS-1:0] s;
      wait_sel_start(4'b0001, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s frame_start: dig_sel=%b, required a transition to 0001", name, dig_sel);
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (i > 0) repeat (PRESCALE) @(negedge clk);
         s = 4'b0001 << i;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard empty at digit %0d", name, i);
         end else begin
            e = exp_q.pop_front();
            if (seg !== e) begin
               n_fail++;
               $display("FAIL %s seg digit %0d: got %h, required %h", name, i, seg, e);
            end
         end
         n_checks++;
         if (dig_sel !== s) begin
            n_fail++;
            $display("FAIL %s dig_sel slot %0d: got %b, required %b", name, i, dig_sel, s);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; ena = 1'b1; bcd_valid = 1'b0; bcd_in = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (seg !== 7'h00) begin n_fail++; $display("FAIL reset seg: got %h, required 00", seg); end
      n_checks++;
      if (dig_sel !== 4'b0000) begin n_fail++; $display("FAIL reset dig_sel: got %b, required 0000", dig_sel); end
      n_checks++;
      if (bcd_ready !== 1'b1) begin n_fail++; $display("FAIL reset bcd_ready: got %b, required 1", bcd_ready); end
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b, required 0", err); end
      push_frame(16'h0000);
      push_frame(16'h0000);
      rst_n = 1'b1;
      drain_frame("reset_frame0");
      drain_frame("reset_frame1");
   endtask

   task automatic test_single;
      bit ok;
      wait_sel_start(4'b0010, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL single wait_slot1: dig_sel=%b, required 0010", dig_sel); end
      bcd_in = 16'h0407; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      n_checks++;
      if (bcd_ready !== 1'b0) begin n_fail++; $display("FAIL single ready_low: got %b, required 0", bcd_ready); end
      n_checks++;
      if (seg !== 7'h00) begin n_fail++; $display("FAIL single old_data: got %h, required 00", seg); end
      push_frame(16'h0407);
      drain_frame("single_0407");
      n_checks++;
      if (bcd_ready !== 1'b1) begin n_fail++; $display("FAIL single ready_high: got %b, required 1", bcd_ready); end
   endtask

   task automatic test_back_to_back;
      bcd_in = 16'h1234; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_in = 16'h5678;
      n_checks++;
      if (bcd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b ready_after_first: got %b, required 0", bcd_ready); end
      push_frame(16'h1234);
      push_frame(16'h5678);
      fork
         begin
            int k;
            k = 0;
            while (bcd_ready !== 1'b1 && k < 4 * DIGITS * PRESCALE) begin
               @(negedge clk);
               k++;
            end
            n_checks++;
            if (bcd_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b second_accept: ready=%b, required 1 within bound", bcd_ready);
            end
            @(negedge clk);
            bcd_valid = 1'b0;
            n_checks++;
            if (bcd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b second_taken: got %b, required 0", bcd_ready); end
         end
         begin
            drain_frame("b2b_1234");
            drain_frame("b2b_5678");
         end
      join
   endtask

   task automatic test_invalid;
      bcd_in = 16'h00A0; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL invalid err_set: got %b, required 1", err); end
      push_frame(16'h00A0);
      drain_frame("invalid_00A0");
      bcd_in = 16'h0001; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      push_frame(16'h0001);
      drain_frame("after_invalid_0001");
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL invalid err_sticky: got %b, required 1", err); end
   endtask

   task automatic test_enable_hold;
      bit ok;
      int cnt;
      wait_sel_start(4'b0001, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL ena wait_slot0: dig_sel=%b, required 0001", dig_sel); end
      ena = 1'b0;
      bcd_in = 16'h0099; bcd_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bcd_valid = 1'b0;
            n_checks++;
            if (bcd_ready !== 1'b0) begin n_fail++; $display("FAIL ena accept_while_off: ready=%b, required 0", bcd_ready); end
         end
         n_checks++;
         if (seg !== 7'h06 || dig_sel !== 4'b0001) begin
            n_fail++;
            $display("FAIL ena hold cycle %0d: seg=%h dig_sel=%b, required 06/0001", k, seg, dig_sel);
         end
      end
      ena = 1'b1;
      cnt = 0;
      while (dig_sel === 4'b0001 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (cnt != PRESCALE) begin n_fail++; $display("FAIL ena resume_cycles: got %0d, required %0d", cnt, PRESCALE); end
      n_checks++;
      if (seg !== 7'h00) begin n_fail++; $display("FAIL ena no_early_swap: seg=%h, required 00", seg); end
      push_frame(16'h0099);
      drain_frame("ena_0099");
   endtask

   task automatic test_reset_mid_frame;
      bit ok;
      wait_sel_start(4'b0001, ok);
      bcd_in = 16'h0555; bcd_valid = 1'b1;
      @(negedge clk);
      bcd_valid = 1'b0;
      n_checks++;
      if (bcd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid staged: ready=%b, required 0", bcd_ready); end
      wait_sel_start(4'b0100, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rst_mid wait_slot2: dig_sel=%b, required 0100", dig_sel); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (seg !== 7'h00 || dig_sel !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mid async_outputs: seg=%h dig_sel=%b, required 00/0000", seg, dig_sel);
      end
      n_checks++;
      if (bcd_ready !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid async_flags: ready=%b err=%b, required 1/0", bcd_ready, err);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_frame(16'h0000);
      push_frame(16'h0000);
      drain_frame("rst_mid_frame0");
      drain_frame("rst_mid_frame1");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_invalid();
      test_enable_hold();
      test_reset_mid_frame();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard leftover: %0d entries, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
